// File: rtl/pmips_pkg.sv
// Shared definitions for the 16-bit pipelined MIPS core: data widths,
// instruction field bounds, jump opcodes and the bubble encoding.
package pmips_pkg;

    localparam int INSTR_W = 16;
    localparam int ADDR_W  = 16;

    localparam int OP_HI = 15;
    localparam int OP_LO = 13;
    localparam int JT_HI = 12;
    localparam int JT_LO = 0;

    typedef logic [OP_HI-OP_LO:0] opcode_t;

    localparam opcode_t OP_JAL = 3'd1;
    localparam opcode_t OP_J   = 3'd2;

    localparam logic [INSTR_W-1:0] NOP = 16'h0000;

    // True for the unconditional jumps resolved inside the fetch stage.
    function automatic logic is_jump(input logic [INSTR_W-1:0] instr);
        opcode_t op;
        op = instr[OP_HI:OP_LO];
        return (op == OP_J) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction memory port, hazard/redirect controls and
// the IF/ID pipeline register outputs.
interface if_stage_if;
    import pmips_pkg::*;

    logic [ADDR_W-1:0]  iaddr;
    logic [INSTR_W-1:0] idata;
    logic               stall;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [ADDR_W-1:0]  if_id_pc_plus2;
    logic               if_id_valid;

    modport master (
        output iaddr,
        input  idata,
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        output if_id_instr,
        output if_id_pc_plus2,
        output if_id_valid
    );

    modport slave (
        input  iaddr,
        output idata,
        output stall,
        output redirect_valid,
        output redirect_pc,
        input  if_id_instr,
        input  if_id_pc_plus2,
        input  if_id_valid
    );

endinterface

// File: rtl/if_stage_pc_next.sv
// Combinational next-PC selection: redirect, then stall, then in-stage jump,
// then sequential fetch. PC+2 wraps modulo 2^16.
module pc_next
    import pmips_pkg::*;
(
    input  logic [ADDR_W-1:0]  pc,
    input  logic [INSTR_W-1:0] idata,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic [ADDR_W-1:0]  pc_plus2,
    output logic [ADDR_W-1:0]  pc_nxt
);

    assign pc_plus2 = pc + 16'd2;

    // Priority mux; jump target keeps the top two bits of the sequential PC.
    always_comb begin
        pc_nxt = pc_plus2;
        if (redirect_valid) begin
            pc_nxt = redirect_pc & ~16'h0001;
        end else if (stall) begin
            pc_nxt = pc;
        end else if (is_jump(idata)) begin
            pc_nxt = {pc_plus2[ADDR_W-1:ADDR_W-2], idata[JT_HI:JT_LO], 1'b0};
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register driving the instruction memory and
// the IF/ID pipeline register. Jumps resolve here with no bubble; a
// downstream redirect flushes IF/ID for one slot.
module if_stage
    import pmips_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
)
(
    input  logic        clock,
    input  logic        reset_n,
    if_stage_if.master  bus
);

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_plus2;
    logic [ADDR_W-1:0]  pc_nxt;
    logic [INSTR_W-1:0] instr_q;
    logic [ADDR_W-1:0]  pc_plus2_q;
    logic               valid_q;

    pc_next u_pc_next (
        .pc             (pc),
        .idata          (bus.idata),
        .stall          (bus.stall),
        .redirect_valid (bus.redirect_valid),
        .redirect_pc    (bus.redirect_pc),
        .pc_plus2       (pc_plus2),
        .pc_nxt         (pc_nxt)
    );

    // PC register; pc_next already folds in the stall hold.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc <= RESET_PC & ~16'h0001;
        end else begin
            pc <= pc_nxt;
        end
    end

    // IF/ID register: flush on redirect, hold on stall, else capture fetch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_q    <= NOP;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (bus.redirect_valid) begin
            instr_q    <= NOP;
            pc_plus2_q <= '0;
            valid_q    <= 1'b0;
        end else if (!bus.stall) begin
            instr_q    <= bus.idata;
            pc_plus2_q <= pc_plus2;
            valid_q    <= 1'b1;
        end
    end

    assign bus.iaddr          = pc;
    assign bus.if_id_instr    = instr_q;
    assign bus.if_id_pc_plus2 = pc_plus2_q;
    assign bus.if_id_valid    = valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for the fetch stage with a word-addressed instruction memory.
module tb_if_stage;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_pass;
    logic watch10;
    logic seen10;

    logic [15:0] mem [0:32767];

    if_stage_if bus ();

    if_stage #(.RESET_PC(16'h0000)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.idata = mem[bus.iaddr[15:1]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(bus.iaddr) begin
        if (watch10 && bus.iaddr == 16'h000A) seen10 = 1'b1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic [48:0] got;
        reset_n = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        #2;
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0000, 16'h0000, 16'h0000, 1'b0})
            $display("FAIL reset_state: got %h expected %h", got, {16'h0000, 16'h0000, 16'h0000, 1'b0});
        else n_pass++;
        step();
        n_checks++;
        if (bus.iaddr !== 16'h0000 || bus.if_id_valid !== 1'b0)
            $display("FAIL reset_hold: iaddr %h valid %b expected 0000 0", bus.iaddr, bus.if_id_valid);
        else n_pass++;
        reset_n = 1'b1;
    endtask

    task automatic test_first_fetch();
        logic [48:0] got;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0002, 16'h6083, 16'h0002, 1'b1})
            $display("FAIL first_fetch: got %h expected %h", got, {16'h0002, 16'h6083, 16'h0002, 1'b1});
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [48:0] got;
        step();
        n_checks++;
        if (bus.iaddr !== 16'h0004)
            $display("FAIL stall_setup: iaddr %h expected 0004", bus.iaddr);
        else n_pass++;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
            n_checks++;
            if (got !== {16'h0004, 16'h6102, 16'h0004, 1'b1})
                $display("FAIL stall_hold_%0d: got %h expected %h", i, got, {16'h0004, 16'h6102, 16'h0004, 1'b1});
            else n_pass++;
        end
        bus.stall = 1'b0;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0006, 16'h6203, 16'h0006, 1'b1})
            $display("FAIL stall_release: got %h expected %h", got, {16'h0006, 16'h6203, 16'h0006, 1'b1});
        else n_pass++;
    endtask

    task automatic test_jal();
        logic [48:0] got;
        seen10 = 1'b0;
        watch10 = 1'b1;
        step();
        n_checks++;
        if (bus.iaddr !== 16'h0008 || bus.if_id_instr !== 16'h6304)
            $display("FAIL jal_setup: iaddr %h instr %h expected 0008 6304", bus.iaddr, bus.if_id_instr);
        else n_pass++;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0002, 16'h2001, 16'h000A, 1'b1})
            $display("FAIL jal_taken: got %h expected %h", got, {16'h0002, 16'h2001, 16'h000A, 1'b1});
        else n_pass++;
        repeat (4) step();
        watch10 = 1'b0;
        n_checks++;
        if (bus.iaddr !== 16'h0002)
            $display("FAIL jal_loop: iaddr %h expected 0002", bus.iaddr);
        else n_pass++;
        n_checks++;
        if (seen10 !== 1'b0)
            $display("FAIL jal_no_slot: saw iaddr 000A flag %b expected 0", seen10);
        else n_pass++;
    endtask

    task automatic test_redirect();
        logic [48:0] got;
        bus.stall = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0013;
        step();
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0012, 16'h0000, 16'h0000, 1'b0})
            $display("FAIL redirect_flush: got %h expected %h", got, {16'h0012, 16'h0000, 16'h0000, 1'b0});
        else n_pass++;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0014, 16'h8421, 16'h0014, 1'b1})
            $display("FAIL redirect_resume: got %h expected %h", got, {16'h0014, 16'h8421, 16'h0014, 1'b1});
        else n_pass++;
    endtask

    task automatic test_wrap();
        logic [48:0] got;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFE;
        step();
        bus.redirect_valid = 1'b0;
        n_checks++;
        if (bus.iaddr !== 16'hFFFE || bus.if_id_valid !== 1'b0)
            $display("FAIL wrap_setup: iaddr %h valid %b expected fffe 0", bus.iaddr, bus.if_id_valid);
        else n_pass++;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0000, 16'h6001, 16'h0000, 1'b1})
            $display("FAIL wrap: got %h expected %h", got, {16'h0000, 16'h6001, 16'h0000, 1'b1});
        else n_pass++;
    endtask

    task automatic test_jump_high();
        logic [48:0] got;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hC000;
        step();
        bus.redirect_valid = 1'b0;
        bus.stall = 1'b1;
        step();
        n_checks++;
        if (bus.iaddr !== 16'hC000 || bus.if_id_valid !== 1'b0)
            $display("FAIL jump_stalled: iaddr %h valid %b expected c000 0", bus.iaddr, bus.if_id_valid);
        else n_pass++;
        bus.stall = 1'b0;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'hC00A, 16'h4005, 16'hC002, 1'b1})
            $display("FAIL jump_high: got %h expected %h", got, {16'hC00A, 16'h4005, 16'hC002, 1'b1});
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [48:0] got;
        #3;
        reset_n = 1'b0;
        #1;
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0000, 16'h0000, 16'h0000, 1'b0})
            $display("FAIL reset_async: got %h expected %h", got, {16'h0000, 16'h0000, 16'h0000, 1'b0});
        else n_pass++;
        step();
        reset_n = 1'b1;
        step();
        got = {bus.iaddr, bus.if_id_instr, bus.if_id_pc_plus2, bus.if_id_valid};
        n_checks++;
        if (got !== {16'h0002, 16'h6083, 16'h0002, 1'b1})
            $display("FAIL reset_restart: got %h expected %h", got, {16'h0002, 16'h6083, 16'h0002, 1'b1});
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        watch10 = 1'b0;
        seen10 = 1'b0;
        for (int i = 0; i < 32768; i++) mem[i] = 16'h0000;
        mem[0]       = 16'h6083;
        mem[1]       = 16'h6102;
        mem[2]       = 16'h6203;
        mem[3]       = 16'h6304;
        mem[4]       = 16'h2001;
        mem[5]       = 16'h6405;
        mem[9]       = 16'h8421;
        mem[16'h7FFF] = 16'h6001;
        mem[16'h6000] = 16'h4005;
        mem[16'h6005] = 16'h2003;

        test_reset();
        test_first_fetch();
        test_stall();
        test_jal();
        test_redirect();
        test_wrap();
        test_jump_high();
        test_reset_mid();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation time exceeded, checks %0d passed %0d", n_checks, n_pass);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit pipelined MIPS core. Owns the program counter, drives the combinational instruction memory's address, and registers the returned instruction into the IF/ID pipeline register for decode. Resolves unconditional jumps (`j`, `jal`) in-stage with zero bubbles. Accepts stall requests from hazard logic and PC redirects for branches resolved later in the pipeline.

## Interface

- `RESET_PC`, default 16'h0000: byte address fetched first after reset.

Clocking: one clock (`clock`); reset (`reset_n`) is asynchronous and active-low.

- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `iaddr` out 16: byte address to the instruction memory; equals the PC register.
- `idata` in 16: instruction returned combinationally for `iaddr`.
- `stall` in 1: hold the PC and the IF/ID register this cycle.
- `redirect_valid` in 1: a taken branch was resolved downstream; load `redirect_pc`.
- `redirect_pc` in 16: redirect target; bit 0 ignored and forced to 0.
- `if_id_instr` out 16: registered instruction.
- `if_id_pc_plus2` out 16: registered PC+2 of that instruction; used as the `jal` link value.
- `if_id_valid` out 1: the IF/ID contents are a real instruction, not a bubble.

## Operation

- Instruction fields: op = [15:13], jump target = [12:0] (word index).
  - `OP_JAL` = 3'd1, `OP_J` = 3'd2.
- Jump target byte address = {pc_plus2[15:14], idata[12:0], 1'b0}.
- Next-PC priority, evaluated each rising edge:
  1. `redirect_valid`: PC <= {redirect_pc[15:1], 0}. IF/ID flushed: valid=0, instr=0, pc_plus2=0.
  2. `stall`: PC and all IF/ID outputs hold.
  3. op of `idata` is `OP_J` or `OP_JAL`: PC <= jump target. IF/ID <= {idata, pc+2, valid=1}.
  4. Otherwise: PC <= pc+2. IF/ID <= {idata, pc+2, valid=1}.
- `redirect_valid` overrides `stall` in the same cycle.
- A jump in `idata` is ignored while stalled or redirected.
- PC+2 is modulo 2^16: 16'hFFFE -> 16'h0000. PC bit 0 is always 0.
- There is no branch delay slot. The instruction at a jump's PC+2 is never fetched on that path.
- `jal` link data reaches decode via `if_id_pc_plus2`. This stage writes no register.

## Timing

- Reset (asynchronous, immediate):
  - `iaddr`=RESET_PC
  - `if_id_instr`=16'h0000
  - `if_id_pc_plus2`=16'h0000
  - `if_id_valid`=0
- First edge after reset release: IF/ID holds the instruction at RESET_PC with valid=1. `iaddr`=RESET_PC+2, or the jump target.
- Fetch-to-IF/ID latency: 1 cycle.
- Jump penalty: 0 cycles.
- Redirect penalty: 1 bubble (the valid=0 slot written on the redirect edge).
- `iaddr` changes only on clock edges or on reset assertion. It is a pure register output with no combinational path from any input.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately. Pending requests are discarded.

## Structure

- Shared package `pmips_pkg`:
  - `OP_J`, `OP_JAL`
  - opcode field bounds
  - `INSTR_W`=16, `ADDR_W`=16
  - `NOP`=16'h0000
- Sub-module `pc_next`: combinational next-PC mux (priority, jump-target formation, wrap).
- `if_stage` holds the PC register and the IF/ID register.

## Test plan

- Reset, then release with the memory holding 16'h6083 (`addi $1,$0,3`) at 0:
  - During reset: `iaddr`=0, valid=0.
  - After edge 1: `if_id_instr`=16'h6083, `if_id_pc_plus2`=2, `iaddr`=2.
- `jal` 16'h2001 at address 8:
  - After that edge: `iaddr`=16'h0002, `if_id_instr`=16'h2001, `if_id_pc_plus2`=16'h000A, valid=1.
  - Address 10 is never presented.
- `stall`=1 for 3 cycles at PC=4:
  - `iaddr` stays 4; IF/ID outputs unchanged.
  - After release, the next edge advances to 6.
- `redirect_valid`=1 with `redirect_pc`=16'h0013, together with `stall`=1:
  - `iaddr`=16'h0012 and valid=0 after the edge.
  - The following edge produces valid=1.
- PC=16'hFFFE with a non-jump instruction: `iaddr` wraps to 16'h0000; `if_id_pc_plus2`=16'h0000.
- `reset_n` pulled low between edges during a jump fetch: outputs go to reset values immediately, without waiting for a clock edge.
